// File: rtl/seqdet_ctrl.sv
// rtl/seqdet_ctrl.sv - configurable serial pattern detector with run/stop control and match counting
module seqdet_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_target,
    input  logic              start,
    input  logic              stop,
    input  logic              x,
    input  logic              x_valid,
    output logic              x_ready,
    output logic              z,
    output logic [CNTW-1:0]   match_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [MAXLEN-1:0] sr;
    logic [MAXLEN-1:0] pattern;
    logic [3:0]        len;
    logic [3:0]        fill;
    logic              overlap;
    logic [CNTW-1:0]   target;

    logic [MAXLEN-1:0] len_mask;
    logic [MAXLEN-1:0] sr_next;
    logic [3:0]        fill_inc;
    logic [CNTW-1:0]   cnt_inc;
    logic              xfer;
    logic              hit;
    logic              len_ok;

    assign x_ready = (state == RUN);
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

    // Only the low len bits of the shift register take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            if (i < int'(len)) len_mask[i] = 1'b1;
        end
    end

    assign len_ok   = (len != 4'd0) && (int'(len) <= MAXLEN);
    assign xfer     = (state == RUN) && x_valid;
    assign sr_next  = {sr[MAXLEN-2:0], x};
    assign fill_inc = (fill >= len) ? len : fill + 4'd1;
    assign hit      = xfer && (fill_inc >= len) && (((sr_next ^ pattern) & len_mask) == '0);
    assign cnt_inc  = (match_cnt == '1) ? match_cnt
                                        : match_cnt + {{(CNTW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            fill      <= '0;
            pattern   <= '0;
            len       <= '0;
            overlap   <= 1'b0;
            target    <= '0;
            match_cnt <= '0;
            z         <= 1'b0;
            err       <= 1'b0;
        end else begin
            z   <= 1'b0;
            err <= 1'b0;

            if (xfer) begin
                sr   <= sr_next;
                fill <= fill_inc;
                if (hit) begin
                    z         <= 1'b1;
                    match_cnt <= cnt_inc;
                    if (!overlap) fill <= '0;
                end
            end

            if (cfg_we) begin
                if (state == IDLE) begin
                    pattern <= cfg_pattern;
                    len     <= cfg_len;
                    overlap <= cfg_overlap;
                    target  <= cfg_target;
                end else begin
                    err <= 1'b1;
                end
            end

            unique case (state)
                IDLE, DONE: begin
                    // stop takes priority over a simultaneous start
                    if (stop) begin
                        state <= IDLE;
                    end else if (start) begin
                        if (len_ok) begin
                            state     <= RUN;
                            match_cnt <= '0;
                            sr        <= '0;
                            fill      <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (hit && (target != '0) && (cnt_inc == target)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seqdet_ctrl.md
SEQDET_CTRL -- requirements
Module: seqdet_ctrl

Interface
REQ-001 Parameter MAXLEN, default 8: maximum pattern length in bits.
REQ-002 Parameter CNTW, default 8: width of the match counter and target.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cfg_we  input  1  configuration write strobe.
REQ-006 cfg_pattern  input  MAXLEN  pattern; the first-received bit is cfg_pattern[len-1] and the last-received bit is cfg_pattern[0].
REQ-007 cfg_len  input  4  pattern length; legal range 1..MAXLEN.
REQ-008 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 cfg_target  input  CNTW  match count that ends a run; 0 = unlimited.
REQ-010 start  input  1  begin run (single-cycle pulse).
REQ-011 stop  input  1  abort run (single-cycle pulse).
REQ-012 x  input  1  serial data bit.
REQ-013 x_valid  input  1  x is valid this cycle.
REQ-014 x_ready  output  1  controller accepts a bit; a bit is transferred when x_valid and x_ready are both high at a rising edge.
REQ-015 z  output  1  registered match pulse.
REQ-016 match_cnt  output  CNTW  matches counted in the current run.
REQ-017 busy  output  1  high in RUN.
REQ-018 done  output  1  high in DONE.
REQ-019 err  output  1  one-cycle error pulse.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-021 x_ready SHALL equal 1 only in RUN, and SHALL be a pure decode of the state.
REQ-022 cfg_we in IDLE SHALL latch pattern, len, overlap and target on that edge; cfg_we in RUN or DONE SHALL be ignored and SHALL pulse err on the next cycle.
REQ-023 start in IDLE or DONE with latched len in 1..MAXLEN SHALL clear match_cnt, the shift register and the fill count, and SHALL enter RUN on the next edge.
REQ-024 start with latched len 0 or len > MAXLEN SHALL pulse err and leave the state unchanged.
REQ-025 start in RUN SHALL be ignored.
REQ-026 Each transfer SHALL shift x into the shift register: sr <= {sr[MAXLEN-2:0], x}.
REQ-027 Each transfer SHALL increment the fill count, saturating at len.
REQ-028 A match SHALL occur on a transfer when the post-shift fill count >= len and post-shift sr[len-1:0] == pattern[len-1:0].
REQ-029 On a match, z SHALL be 1 for exactly the cycle following the transfer edge; otherwise z SHALL be 0.
REQ-030 On a match, match_cnt SHALL increment, saturating at 2^CNTW-1.
REQ-031 In non-overlap mode, a match SHALL reset the fill count to 0, so a new match needs len fresh bits.
REQ-032 In overlap mode, a match SHALL leave the fill count unchanged.
REQ-033 When target != 0 and a match makes match_cnt equal target, the FSM SHALL enter DONE on the same edge, and x_ready SHALL be 0 from the next cycle.
REQ-034 In DONE, match_cnt and done SHALL hold until start or stop.
REQ-035 stop in RUN or DONE SHALL enter IDLE on the next edge; match_cnt SHALL hold its value in IDLE.
REQ-036 A transfer on the same edge as stop SHALL still be shifted, matched and counted.
REQ-037 start and stop asserted together: stop SHALL win.
REQ-038 No transfer SHALL occur outside RUN, regardless of x_valid.
REQ-039 The fill count and sr SHALL be unaffected in cycles without a transfer, so gaps in x_valid are transparent.

Reset
REQ-040 While rst is low, the outputs SHALL be: state IDLE, x_ready 0, z 0, match_cnt 0, busy 0, done 0, err 0.
REQ-041 While rst is low, the internal state SHALL be: sr 0, fill count 0, pattern 0, len 0, overlap 0, target 0.
REQ-042 Reset asserted mid-run SHALL abort immediately, without completing the current transfer.
REQ-043 After reset, start without a prior cfg_we SHALL produce err, because len is 0.

Verification
REQ-044 cfg pattern=101, len=3, overlap=1, target=0; start; stream 1,0,1,0,1 -> z pulses after bits 3 and 5; match_cnt=2.
REQ-045 Same stimulus with overlap=0 -> z pulses after bit 3 only; match_cnt=1; a further 0,1 -> second pulse, match_cnt=2.
REQ-046 target=2, overlap=1, stream 1,0,1,0,1,0,1 -> done=1 after bit 5; x_ready=0; bits 6-7 not accepted; match_cnt stays 2.
REQ-047 cfg_we in RUN with pattern=111 -> err pulses once; detection still uses 101.
REQ-048 x_valid toggled 1,0,1,0 around stream 1,0,1 -> single z pulse, identical to the gapless case.
REQ-049 rst low for one cycle mid-stream -> all outputs 0 and state IDLE; subsequent start -> err (len cleared).
